next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 136 +++++++++++++
 tb/tb_next_pc_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Next fetch-address generator: target select, alignment, and a circular
// return-address stack for call/return prediction.
module next_pc_unit #(
   parameter int unsigned     WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [WIDTH-1:0] EXC_ADDR   = 32'h8000_0004,
   parameter int unsigned     RAS_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       pc_src,
   input  logic [WIDTH-1:0] branch_addr,
   input  logic [WIDTH-1:0] jump_addr,
   input  logic [WIDTH-1:0] reg_addr,
   input  logic [WIDTH-1:0] ret_link,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             misalign,
   output logic             ras_miss
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [2:0] SRC_BRANCH = 3'd1;
   localparam logic [2:0] SRC_JUMP   = 3'd2;
   localparam logic [2:0] SRC_REG    = 3'd3;
   localparam logic [2:0] SRC_CALL   = 3'd4;
   localparam logic [2:0] SRC_RET    = 3'd5;
   localparam logic [2:0] SRC_EXC    = 3'd6;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             misalign_q, misalign_d;
   logic             ras_miss_q, ras_miss_d;
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

   logic [WIDTH-1:0] raw_target;
   logic             check_align;
   logic             push;
   logic [PTR_W-1:0] ptr_inc;

   assign pc        = pc_q;
   assign pc_plus4  = pc_q + WIDTH'(4);
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
   assign misalign  = misalign_q;
   assign ras_miss  = ras_miss_q;
   assign ptr_inc   = ptr_q + PTR_W'(1);

   always_comb begin
      raw_target  = pc_plus4;
      check_align = 1'b0;
      push        = 1'b0;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      ras_miss_d  = 1'b0;
      case (pc_src)
         SRC_BRANCH: begin
            raw_target  = branch_addr;
            check_align = 1'b1;
         end
         SRC_JUMP: begin
            raw_target  = jump_addr;
            check_align = 1'b1;
         end
         SRC_REG: begin
            raw_target  = reg_addr;
            check_align = 1'b1;
         end
         SRC_CALL: begin
            raw_target  = jump_addr;
            check_align = 1'b1;
            push        = 1'b1;
            ptr_d       = ptr_inc;
            // When full the write lands on the oldest entry; count saturates.
            if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
         end
         SRC_RET: begin
            check_align = 1'b1;
            if (ras_empty) begin
               raw_target = reg_addr;
               ras_miss_d = 1'b1;
            end else begin
               raw_target = ras_mem[ptr_q];
               ptr_d      = ptr_q - PTR_W'(1);
               cnt_d      = cnt_q - CNT_W'(1);
            end
         end
         SRC_EXC: begin
            raw_target = EXC_ADDR;
            cnt_d      = '0;
         end
         default: ;
      endcase

      pc_d       = {raw_target[WIDTH-1:2], 2'b00};
      misalign_d = check_align && (raw_target[1:0] != 2'b00);

      // Exceptions override stall; everything else freezes.
      if (stall && (pc_src != SRC_EXC)) begin
         pc_d       = pc_q;
         ptr_d      = ptr_q;
         cnt_d      = cnt_q;
         push       = 1'b0;
         misalign_d = 1'b0;
         ras_miss_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_ADDR;
         ptr_q      <= '0;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
         ras_miss_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         misalign_q <= misalign_d;
         ras_miss_q <= ras_miss_d;
      end
   end

   // Entry storage is never read before being written, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) ras_mem[ptr_inc] <= {ret_link[WIDTH-1:2], 2'b00};
   end

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: a reference model queues the expected
// outputs per driven cycle and they are compared one edge later.
module tb_next_pc_unit;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RST_A = 32'h0000_0000;
   localparam logic [31:0] EXC_A = 32'h8000_0004;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [2:0]  pc_src;
   logic [31:0] branch_addr, jump_addr, reg_addr, ret_link;
   logic [31:0] pc, pc_plus4;
   logic        ras_empty, ras_full, misalign, ras_miss;

   typedef struct packed {
      logic [31:0] pc;
      logic        mis;
      logic        miss;
      logic        empty;
      logic        full;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   logic [31:0] m_pc;
   logic [31:0] m_ras [DEPTH];
   int          m_ptr;
   int          m_cnt;

   always #5 clk = ~clk;

   next_pc_unit #(
      .WIDTH      (WIDTH),
      .RESET_ADDR (RST_A),
      .EXC_ADDR   (EXC_A),
      .RAS_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .pc_src      (pc_src),
      .branch_addr (branch_addr),
      .jump_addr   (jump_addr),
      .reg_addr    (reg_addr),
      .ret_link    (ret_link),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .ras_empty   (ras_empty),
      .ras_full    (ras_full),
      .misalign    (misalign),
      .ras_miss    (ras_miss)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = RST_A;
      m_ptr = 0;
      m_cnt = 0;
   endtask

   // Drive one cycle, queue the model's expectation, compare after the edge.
   task automatic step(input logic st, input logic [2:0] src, input logic [31:0] b,
                       input logic [31:0] j, input logic [31:0] r, input logic [31:0] l);
      exp_t        e;
      exp_t        g;
      logic [31:0] raw;
      bit          chk;
      bit          miss;
      stall = st; pc_src = src; branch_addr = b; jump_addr = j; reg_addr = r; ret_link = l;
      chk  = 0;
      miss = 0;
      raw  = m_pc + 32'd4;
      if (!(st && src != 3'd6)) begin
         case (src)
            3'd1: begin raw = b; chk = 1; end
            3'd2: begin raw = j; chk = 1; end
            3'd3: begin raw = r; chk = 1; end
            3'd4: begin
               raw = j; chk = 1;
               m_ptr = (m_ptr + 1) % DEPTH;
               m_ras[m_ptr] = l & ~32'h3;
               if (m_cnt < DEPTH) m_cnt++;
            end
            3'd5: begin
               chk = 1;
               if (m_cnt == 0) begin
                  raw = r; miss = 1;
               end else begin
                  raw = m_ras[m_ptr];
                  m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                  m_cnt--;
               end
            end
            3'd6: begin raw = EXC_A; m_cnt = 0; end
            default: raw = m_pc + 32'd4;
         endcase
         m_pc  = raw & ~32'h3;
         e.mis = chk && (raw[1:0] != 2'b00);
      end else begin
         e.mis = 1'b0;
      end
      e.pc    = m_pc;
      e.miss  = miss;
      e.empty = (m_cnt == 0);
      e.full  = (m_cnt == DEPTH);
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check_eq("pc", pc, g.pc);
      check_eq("pc_plus4", pc_plus4, g.pc + 32'd4);
      check_eq("misalign", {31'd0, misalign}, {31'd0, g.mis});
      check_eq("ras_miss", {31'd0, ras_miss}, {31'd0, g.miss});
      check_eq("ras_empty", {31'd0, ras_empty}, {31'd0, g.empty});
      check_eq("ras_full", {31'd0, ras_full}, {31'd0, g.full});
   endtask

   task automatic seq();
      step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_pc"}, pc, RST_A);
      check_eq({tag, "_empty"}, {31'd0, ras_empty}, 32'd1);
      check_eq({tag, "_full"}, {31'd0, ras_full}, 32'd0);
      check_eq({tag, "_mis"}, {31'd0, misalign}, 32'd0);
      check_eq({tag, "_miss"}, {31'd0, ras_miss}, 32'd0);
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; pc_src = 3'd0;
      branch_addr = '0; jump_addr = '0; reg_addr = '0; ret_link = '0;
      model_reset();
      #12;
      check_reset_state("reset");
      reset = 1'b1;

      // Sequential fetch: 4, 8, 12.
      seq(); seq(); seq();
      check_eq("seq_pc12", pc, 32'd12);

      // Single call / return.
      step(1'b0, 3'd4, 32'h0, 32'h100, 32'h0, 32'h44);
      check_eq("call_pc", pc, 32'h100);
      step(1'b0, 3'd5, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("ret_pc", pc, 32'h44);

      // Overflow: five calls into a 4-deep stack, then five returns.
      for (int i = 1; i <= 5; i++)
         step(1'b0, 3'd4, 32'h0, 32'h200 + 32'(i) * 32'h10, 32'h0, 32'(i) * 32'h10);
      for (int i = 0; i < 5; i++)
         step(1'b0, 3'd5, 32'h0, 32'h0, 32'h99, 32'h0);
      check_eq("ovf_last_miss", {31'd0, ras_miss}, 32'd1);

      // Stall holds pc; exception overrides stall and flushes the stack.
      step(1'b0, 3'd4, 32'h0, 32'h300, 32'h0, 32'h58);
      for (int i = 0; i < 3; i++)
         step(1'b1, 3'd1, 32'h500, 32'h0, 32'h0, 32'h0);
      check_eq("stall_pc", pc, 32'h300);
      step(1'b1, 3'd6, 32'h0, 32'h0, 32'h0, 32'h0);
      check_eq("exc_pc", pc, EXC_A);

      // Misaligned branch.
      step(1'b0, 3'd1, 32'h103, 32'h0, 32'h0, 32'h0);
      check_eq("mis_pc", pc, 32'h100);
      seq();
      check_eq("mis_next_pc", pc, 32'h104);

      // Reserved select behaves as sequential.
      step(1'b0, 3'd7, 32'h40, 32'h40, 32'h40, 32'h0);

      // Asynchronous reset between edges after two calls.
      step(1'b0, 3'd4, 32'h0, 32'h600, 32'h0, 32'h64);
      step(1'b0, 3'd4, 32'h0, 32'h700, 32'h0, 32'h74);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("async");
      model_reset();
      #1;
      reset = 1'b1;
      step(1'b0, 3'd5, 32'h0, 32'h0, 32'h88, 32'h0);
      check_eq("post_rst_miss", {31'd0, ras_miss}, 32'd1);

      // Random mix.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom(),
              $urandom(), $urandom(), $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
